gate_truth_checker: RTL and testbench

Synthesizable self-checking driver for a 2-input combinational gate. It walks the four input vectors {a,b} = 00, 01, 10, 11 into the device under check. It samples the device output after a programmable settle time and compares it against a parameterised expected truth table. It reports per-vector pass/fail status. It sits beside small logic-gate blocks in the lab as the in-hardware stimulus-plus-monitor, so a gate can be exercised on silicon or FPGA without a simulation bench.

---
 rtl/gate_truth_checker.sv | 118 +++++++++++
 tb/tb_gate_truth_checker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// Walks {a,b} = 00..11 into a 2-input gate, samples y after SETTLE extra cycles, and flags mismatches against TRUTH.
// Run latency 4*(SETTLE+1) cycles from the start edge to done; start is ignored while busy or done, and abort cancels a run.
module gate_truth_checker #(
    parameter logic [3:0]  TRUTH  = 4'b1000,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] fail_count
);

    localparam logic [3:0] SETTLE_C = SETTLE[3:0];

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    state_t     state_q;
    logic [1:0] idx_q;
    logic [3:0] cnt_q;
    logic       a_q, b_q, busy_q, done_q, pass_q;
    logic [3:0] fail_vec_q;
    logic [2:0] fail_count_q;

    logic       mismatch;
    logic [1:0] idx_d;
    logic [3:0] fail_vec_d;
    logic [2:0] fail_count_d;

    // Result of the sample taken at the end of the current vector slot.
    assign mismatch     = dut_y ^ TRUTH[idx_q];
    assign idx_d        = idx_q + 2'd1;
    assign fail_vec_d   = fail_vec_q | ({3'b000, mismatch} << idx_q);
    assign fail_count_d = fail_count_q + {2'b00, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= 4'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_vec_q   <= 4'd0;
            fail_count_q <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    a_q <= 1'b0;
                    b_q <= 1'b0;
                    if (start) begin
                        state_q      <= S_DRIVE;
                        idx_q        <= 2'd0;
                        cnt_q        <= 4'd0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        fail_vec_q   <= 4'd0;
                        fail_count_q <= 3'd0;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        // Partial flags are kept for inspection; pass stays low.
                        state_q <= S_IDLE;
                        idx_q   <= 2'd0;
                        cnt_q   <= 4'd0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != SETTLE_C) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        fail_vec_q   <= fail_vec_d;
                        fail_count_q <= fail_count_d;
                        if (idx_q == 2'd3) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (fail_vec_d == 4'd0);
                        end else begin
                            idx_q <= idx_d;
                            cnt_q <= 4'd0;
                            a_q   <= idx_d[1];
                            b_q   <= idx_d[0];
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    idx_q   <= 2'd0;
                    cnt_q   <= 4'd0;
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dut_a      = a_q;
    assign dut_b      = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_vec   = fail_vec_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: four checker instances beside modelled gates (AND, OR, stuck-1, slow NAND).
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic start      [4];
    logic abort      [4];
    logic dut_a      [4];
    logic dut_b      [4];
    logic busy       [4];
    logic done       [4];
    logic pass       [4];
    logic [3:0] fail_vec   [4];
    logic [2:0] fail_count [4];
    logic [1:0] mode       [4];   // 0 AND, 1 OR, 2 stuck at 1, 3 NAND settling after 2 cycles

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [3:0]  TR [4] = '{4'b1000, 4'b1110, 4'b0111, 4'b0111};
    localparam int unsigned ST [4] = '{1, 1, 3, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic d1, d2, y;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d1 <= 1'b1;
                d2 <= 1'b1;
            end else begin
                d1 <= ~(dut_a[g] & dut_b[g]);
                d2 <= d1;
            end
        end

        always_comb begin
            y = 1'b0;
            case (mode[g])
                2'd0:    y = dut_a[g] & dut_b[g];
                2'd1:    y = dut_a[g] | dut_b[g];
                2'd2:    y = 1'b1;
                default: y = d2;
            endcase
        end

        gate_truth_checker #(.TRUTH(TR[g]), .SETTLE(ST[g])) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .abort      (abort[g]),
            .dut_a      (dut_a[g]),
            .dut_b      (dut_b[g]),
            .dut_y      (y),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .fail_vec   (fail_vec[g]),
            .fail_count (fail_count[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int i, input string tag);
        int k = 0;
        while (done[i] !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done[i]), 1);
    endtask

    // Runs one check on instance i; called just after an edge with the instance idle.
    task automatic run(input int i, input int fv_exp, input int fc_exp, input int pass_exp,
                       input int restart_at, input string tag);
        int slot   = int'(ST[i]) + 1;
        int k      = 0;
        int badvec = 0;
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy[i]), 1);
        chk({tag, "_cleared"}, {pass[i], fail_count[i], fail_vec[i]}, 0);
        while (done[i] !== 1'b1 && k < 200) begin
            if (int'({dut_a[i], dut_b[i]}) != k / slot) badvec++;
            if (k == restart_at) start[i] = 1'b1;
            @(posedge clk); #1;
            start[i] = 1'b0;
            k++;
        end
        chk({tag, "_latency"}, k, 4 * slot);
        chk({tag, "_busy_at_done"}, 32'(busy[i]), 0);
        chk({tag, "_vector_seq"}, badvec, 0);
        chk({tag, "_fail_vec"}, fail_vec[i], fv_exp);
        chk({tag, "_fail_count"}, fail_count[i], fc_exp);
        chk({tag, "_pass"}, 32'(pass[i]), pass_exp);
        @(posedge clk); #1;
        chk({tag, "_after_done"}, {done[i], busy[i], dut_a[i], dut_b[i]}, 0);
        chk({tag, "_held"}, {pass[i], fail_count[i], fail_vec[i]}, {pass_exp[0], fc_exp[2:0], fv_exp[3:0]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dn;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
        end
        mode[0] = 2'd0; mode[1] = 2'd1; mode[2] = 2'd3; mode[3] = 2'd3;
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 4; i++)
            chk("reset_state", {busy[i], done[i], pass[i], dut_a[i], dut_b[i], fail_vec[i], fail_count[i]}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // AND gate, with a stray start during the run that must be ignored
        run(0, 4'b0000, 0, 1, 3, "and_ok");
        mode[0] = 2'd2;
        run(0, 4'b0111, 3, 0, -1, "stuck1");
        mode[0] = 2'd1;
        run(0, 4'b0110, 2, 0, -1, "or_vs_and");
        run(1, 4'b0000, 0, 1, -1, "or_vs_or");
        mode[0] = 2'd0;
        run(0, 4'b0000, 0, 1, -1, "and_rerun");

        // start held high: back-to-back runs separated by one DONE cycle
        start[1] = 1'b1;
        wait_done(1, "b2b_first");
        @(posedge clk); #1;
        chk("b2b_idle_gap", 32'(busy[1]), 0);
        @(posedge clk); #1;
        chk("b2b_restart", 32'(busy[1]), 1);
        start[1] = 1'b0;
        wait_done(1, "b2b_second");
        chk("b2b_second_pass", 32'(pass[1]), 1);
        @(posedge clk); #1;

        // abort in the idx=2 slot keeps partial flags from vectors 0 and 1
        mode[0] = 2'd2;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_state", {busy[0], dut_a[0], dut_b[0], pass[0]}, 0);
        chk("abort_partial", {fail_count[0], fail_vec[0]}, {3'd2, 4'b0011});
        dn = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1) dn++;
        end
        chk("abort_no_done", dn, 0);

        // asynchronous reset in the middle of a run
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {busy[0], done[0], pass[0], dut_a[0], dut_b[0], fail_vec[0], fail_count[0]}, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("post_reset_idle", {busy[0], done[0]}, 0);

        // slow NAND: passes with SETTLE=3, misses the last vector with SETTLE=0
        run(2, 4'b0000, 0, 1, -1, "slow_s3");
        run(3, 4'b1000, 1, 0, -1, "slow_s0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
